fp_mul_rr_sched: RTL and testbench



---
 rtl/fp_mul_rr_sched.sv | 137 +++++++++++++
 tb/tb_fp_mul_rr_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_rr_sched.sv
// Round-robin scheduler sharing one single-precision FP multiplier among N_REQ requesters.
// Define FP_SCHED_TIMEOUT_EN to bound the multiplier wait to TMO_CYC cycles (NaN + resp_err).
module fp_mul_rr_sched #(
    parameter int N_REQ   = 4,
    parameter int IDW     = 2,
    parameter int TMO_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    resp_valid,
    input  logic [N_REQ-1:0]    resp_ready,
    output logic [31:0]         resp_z,
    output logic                resp_err,
    output logic [IDW-1:0]      grant_id,
    output logic                busy,
    output logic                mul_en,
    output logic [31:0]         mul_a,
    output logic [31:0]         mul_b,
    input  logic [31:0]         mul_z,
    input  logic                mul_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt;
    logic           found;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic           resp_acc;

    // First valid requester strictly after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req_valid[j] && j == (int'(rr_ptr) + i) % N_REQ) begin
                    found = 1'b1;
                    gnt   = IDW'(j);
                end
            end
        end
    end

    always_comb begin
        sel_a      = '0;
        sel_b      = '0;
        req_ready  = '0;
        resp_valid = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (gnt == IDW'(j)) begin
                sel_a = req_a[32*j +: 32];
                sel_b = req_b[32*j +: 32];
            end
            req_ready[j]  = !rst && state == IDLE && found && gnt == IDW'(j);
            resp_valid[j] = state == RESP && grant_id == IDW'(j);
        end
    end

    assign resp_acc = |(resp_valid & resp_ready);
    assign mul_en   = state == ISSUE || state == WAIT;
    assign busy     = state != IDLE;

`ifdef FP_SCHED_TIMEOUT_EN
    localparam int CW = ($clog2(TMO_CYC + 1) > 5) ? $clog2(TMO_CYC + 1) : 5;
    logic [CW-1:0] tmo_cnt;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= IDW'(N_REQ - 1);
            grant_id <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            resp_z   <= '0;
`ifdef FP_SCHED_TIMEOUT_EN
            resp_err <= 1'b0;
            tmo_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= gnt;
                        mul_a    <= sel_a;
                        mul_b    <= sel_b;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef FP_SCHED_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (mul_ready) begin
                        resp_z <= mul_z;
`ifdef FP_SCHED_TIMEOUT_EN
                        resp_err <= 1'b0;
`endif
                        state <= RESP;
                    end
`ifdef FP_SCHED_TIMEOUT_EN
                    else if (tmo_cnt == CW'(TMO_CYC - 1)) begin
                        resp_z   <= 32'hFFC0_0000;
                        resp_err <= 1'b1;
                        state    <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
`endif
                end
                RESP: begin
                    if (resp_acc) begin
                        rr_ptr <= grant_id;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_rr_sched.sv
// Directed bench for fp_mul_rr_sched with a one-cycle-latency multiplier model.
// Covers single op, round robin, response backpressure, reset mid-WAIT and stalled multiplier.
module tb_fp_mul_rr_sched;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [31:0]     resp_z;
    logic            resp_err;
    logic [IDW-1:0]  grant_id;
    logic            busy;
    logic            mul_en;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic [31:0]     mul_z;
    logic            mul_ready = 1'b0;

    logic            rdy_en;
    logic [31:0]     model_z;

    int total = 0;
    int bad   = 0;

    fp_mul_rr_sched #(.N_REQ(N), .IDW(IDW), .TMO_CYC(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_z     (resp_z),
        .resp_err   (resp_err),
        .grant_id   (grant_id),
        .busy       (busy),
        .mul_en     (mul_en),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_z      (mul_z),
        .mul_ready  (mul_ready)
    );

    always #5 clk = ~clk;

    // Multiplier model: output_ready one cycle after enable.
    always @(posedge clk) mul_ready <= mul_en & rdy_en;
    assign mul_z = model_z;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '0;
        rdy_en     = 1'b1;
        model_z    = '0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_en", 32'(mul_en), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_resp_z", resp_z, 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        rst = 1'b0;
        tick();

        // Single request 2.0 * 3.0
        req_valid   = 4'b0001;
        req_a[31:0] = 32'h4000_0000;
        req_b[31:0] = 32'h4040_0000;
        model_z     = 32'h40C0_0000;
        #1;
        chk("single_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("single_req_ready_drop", 32'(req_ready), 32'h0);
        chk("single_mul_a", mul_a, 32'h4000_0000);
        chk("single_mul_b", mul_b, 32'h4040_0000);
        chk("single_issue_en", 32'(mul_en), 32'h1);
        chk("single_busy", 32'(busy), 32'h1);
        tick();
        chk("single_wait_en", 32'(mul_en), 32'h1);
        chk("single_wait_rv", 32'(resp_valid), 32'h0);
        tick();
        chk("single_resp_valid", 32'(resp_valid), 32'h1);
        chk("single_resp_z", resp_z, 32'h40C0_0000);
        chk("single_resp_err", 32'(resp_err), 32'h0);
        chk("single_resp_en", 32'(mul_en), 32'h0);
        resp_ready = 4'b1111;
        tick();
        chk("single_idle_busy", 32'(busy), 32'h0);
        chk("single_idle_rv", 32'(resp_valid), 32'h0);

        // Round robin from reset: grant order 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = 32'h4000_0000 + 32'(i);
            req_b[32*i +: 32] = 32'h4100_0000 + 32'(i);
        end
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            model_z = 32'h3F80_0000 + 32'(k);
            #1;
            chk("rr_req_ready", 32'(req_ready), 32'h1 << (k % N));
            tick();
            chk("rr_grant", 32'(grant_id), 32'(k % N));
            chk("rr_mul_a", mul_a, 32'h4000_0000 + 32'(k % N));
            chk("rr_mul_b", mul_b, 32'h4100_0000 + 32'(k % N));
            chk("rr_ready_busy", 32'(req_ready), 32'h0);
            tick();
            tick();
            chk("rr_resp_valid", 32'(resp_valid), 32'h1 << (k % N));
            chk("rr_resp_z", resp_z, 32'h3F80_0000 + 32'(k));
            tick();
        end
        req_valid = '0;

        // Backpressure on requester 2 with requester 0 pending
        req_valid  = 4'b0100;
        resp_ready = 4'b1011;
        model_z    = 32'h1234_5678;
        #1;
        chk("bp_req_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0001;
        tick();
        tick();
        for (int c = 0; c < 10; c++) begin
            chk("bp_resp_valid", 32'(resp_valid), 32'h4);
            chk("bp_resp_z", resp_z, 32'h1234_5678);
            chk("bp_mul_en", 32'(mul_en), 32'h0);
            chk("bp_no_grant", 32'(req_ready), 32'h0);
            tick();
        end
        resp_ready = 4'b1111;
        #1;
        chk("bp_last_valid", 32'(resp_valid), 32'h4);
        tick();
        chk("bp_idle_busy", 32'(busy), 32'h0);
        chk("bp_next_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("bp_grant0", 32'(grant_id), 32'h0);
        tick();
        tick();
        chk("bp_resp0", 32'(resp_valid), 32'h1);
        tick();

        // Inf * 0 passes the multiplier's NaN straight through
        req_valid      = 4'b0010;
        req_a[63:32]   = 32'h7F80_0000;
        req_b[63:32]   = 32'h0000_0000;
        model_z        = 32'hFFC0_0000;
        #1;
        chk("nan_req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk("nan_mul_a", mul_a, 32'h7F80_0000);
        chk("nan_mul_b", mul_b, 32'h0);
        tick();
        tick();
        chk("nan_resp_valid", 32'(resp_valid), 32'h2);
        chk("nan_resp_z", resp_z, 32'hFFC0_0000);
        chk("nan_resp_err", 32'(resp_err), 32'h0);
        tick();

        // Reset while waiting on the multiplier
        rdy_en    = 1'b0;
        req_valid = 4'b1000;
        #1;
        chk("rw_req_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        tick();
        chk("rw_wait_en", 32'(mul_en), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_mul_en", 32'(mul_en), 32'h0);
        chk("rw_busy", 32'(busy), 32'h0);
        chk("rw_resp_valid", 32'(resp_valid), 32'h0);
        chk("rw_grant", 32'(grant_id), 32'h0);
        chk("rw_mul_a", mul_a, 32'h0);
        chk("rw_resp_z", resp_z, 32'h0);
        rdy_en    = 1'b1;
        req_valid = 4'b0010;
        #1;
        chk("rw_req1_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk("rw_grant1", 32'(grant_id), 32'h1);
        tick();
        tick();
        chk("rw_resp1", 32'(resp_valid), 32'h2);
        tick();

        // Stalled multiplier: grant wraps from 1 to 0
        rdy_en    = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("st_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
`ifdef FP_SCHED_TIMEOUT_EN
        for (int c = 0; c < 16; c++) tick();
        chk("tmo_not_yet", 32'(resp_valid), 32'h0);
        chk("tmo_en_last", 32'(mul_en), 32'h1);
        tick();
        chk("tmo_resp_valid", 32'(resp_valid), 32'h1);
        chk("tmo_resp_z", resp_z, 32'hFFC0_0000);
        chk("tmo_resp_err", 32'(resp_err), 32'h1);
        chk("tmo_mul_en", 32'(mul_en), 32'h0);
`else
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("hang_busy", 32'(busy), 32'h1);
            chk("hang_rv", 32'(resp_valid), 32'h0);
        end
        chk("hang_err", 32'(resp_err), 32'h0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("end_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
